fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/fetch_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - fetch controller bundle: icache/mini-decode inputs, execute redirect/train, fetch outputs
// master is the fetch controller; slave is the surrounding pipeline.
interface fetch_ctrl_if;
  logic        instr_data_ok_i;
  logic        mini_op_branch_i;
  logic        mini_op_jal_i;
  logic [31:0] mini_jal_jmp_i;
  logic [31:0] mini_branch_jmp_i;
  logic        D_stall_i;
  logic        E_redirect_i;
  logic [31:0] E_redirect_pc_i;
  logic        E_train_vaild_i;
  logic [31:0] E_train_pc_i;
  logic        E_train_taken_i;
  logic [31:0] F_PC_o;
  logic        F_valid_o;
  logic        F_pred_taken_o;

  modport master (
    input  instr_data_ok_i, mini_op_branch_i, mini_op_jal_i, mini_jal_jmp_i,
           mini_branch_jmp_i, D_stall_i, E_redirect_i, E_redirect_pc_i,
           E_train_vaild_i, E_train_pc_i, E_train_taken_i,
    output F_PC_o, F_valid_o, F_pred_taken_o
  );

  modport slave (
    output instr_data_ok_i, mini_op_branch_i, mini_op_jal_i, mini_jal_jmp_i,
           mini_branch_jmp_i, D_stall_i, E_redirect_i, E_redirect_pc_i,
           E_train_vaild_i, E_train_pc_i, E_train_taken_i,
    input  F_PC_o, F_valid_o, F_pred_taken_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC sequencer with 2-bit counter branch prediction and redirect handling
// F_PC_o is the registered fetch address; valid/prediction are decoded from it and the current icache response.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int          BHT_ENTRIES = 16
) (
  input  logic   clk_i,
  input  logic   rst,
  fetch_ctrl_if.master bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t             state;
  logic [31:0]        pc_q;
  logic [31:0]        pending_pc;
  logic [1:0]         bht [BHT_ENTRIES];

  logic [IDX_W-1:0]   lookup_idx;
  logic [IDX_W-1:0]   train_idx;
  logic [1:0]         lookup_ctr;
  logic [1:0]         train_ctr;
  logic               pred_branch;
  logic               valid;
  logic               advance;
  logic [31:0]        next_pc;

  assign lookup_idx  = pc_q[IDX_W+1:2];
  assign train_idx   = bus.E_train_pc_i[IDX_W+1:2];
  assign lookup_ctr  = bht[lookup_idx];
  assign train_ctr   = bht[train_idx];
  assign pred_branch = bus.mini_op_branch_i & lookup_ctr[1];

  assign valid   = (state == FETCH) & bus.instr_data_ok_i & ~bus.E_redirect_i;
  assign advance = valid & ~bus.D_stall_i;

  always_comb begin
    next_pc = pc_q + 32'd4;
    if (bus.mini_op_jal_i)
      next_pc = bus.mini_jal_jmp_i;
    else if (pred_branch)
      next_pc = bus.mini_branch_jmp_i;
  end

  assign bus.F_PC_o         = pc_q;
  assign bus.F_valid_o      = valid;
  assign bus.F_pred_taken_o = valid & (bus.mini_op_jal_i | pred_branch);

  // A redirect that arrives while the icache is still busy must wait for the
  // outstanding access to return before the address may change.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      pending_pc <= '0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          if (bus.E_redirect_i)
            pc_q <= bus.E_redirect_pc_i;
        end
        FETCH: begin
          if (bus.E_redirect_i) begin
            if (bus.instr_data_ok_i) begin
              pc_q <= bus.E_redirect_pc_i;
            end else begin
              pending_pc <= bus.E_redirect_pc_i;
              state      <= FLUSH;
            end
          end else if (advance) begin
            pc_q <= next_pc;
          end
        end
        FLUSH: begin
          if (bus.instr_data_ok_i) begin
            pc_q  <= bus.E_redirect_i ? bus.E_redirect_pc_i : pending_pc;
            state <= FETCH;
          end else if (bus.E_redirect_i) begin
            pending_pc <= bus.E_redirect_pc_i;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  // Lookup reads the array combinationally, so a same-cycle update is seen only next cycle.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= 2'b01;
    end else if (bus.E_train_vaild_i) begin
      if (bus.E_train_taken_i) begin
        if (train_ctr != 2'b11)
          bht[train_idx] <= train_ctr + 2'd1;
      end else begin
        if (train_ctr != 2'b00)
          bht[train_idx] <= train_ctr - 2'd1;
      end
    end
  end

endmodule
